mem_image_loader: RTL and testbench
===================================

MEM_IMAGE_LOADER -- requirements
Module: mem_image_loader

Interface
REQ-001 Parameter DATA_W, default 32: stream word width in bits; SHALL be a multiple of 8, at least 8; BYTES = DATA_W/8.
REQ-002 Parameter ADDR_W, default 12: byte-address width; memory holds 2^ADDR_W bytes (0x1000 at default).
REQ-003 Parameter BIG_ENDIAN, default 0: 0 puts lane i (bits 8i+7:8i) at address base+i; 1 puts lane BYTES-1-i there.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Start_load  in  1  one-cycle request to load an image from the input stream.
REQ-007 Start_dump  in  1  one-cycle request to dump memory to the output stream.
REQ-008 Abort  in  1  synchronous cancel of the current operation.
REQ-009 Base_addr  in  ADDR_W  first byte address, sampled on start.
REQ-010 Byte_count  in  ADDR_W+1  number of bytes to transfer, sampled on start.
REQ-011 In_valid / In_ready / In_data  in / out / in  1 / 1 / DATA_W  load stream, valid-ready handshake.
REQ-012 Out_valid / Out_ready / Out_data  out / in / out  1 / 1 / DATA_W  dump stream, valid-ready handshake.
REQ-013 Mem_we / Mem_re  out  1  byte write strobe / byte read strobe.
REQ-014 Mem_addr  out  ADDR_W  byte address for write or read.
REQ-015 Mem_wdata / Mem_rdata  out / in  8  write byte / read byte; read data valid exactly 1 cycle after Mem_re.
REQ-016 Busy / Done / Error  out  1  operation in progress / one-cycle completion pulse / sticky address-wrap flag.

Function
REQ-017 FSM states: IDLE, LOAD_ACC, LOAD_WR, DUMP_RD, DUMP_OUT, DONE; Busy = 1 in every state except IDLE.
REQ-018 IDLE: Start_load -> LOAD_ACC; Start_dump -> DUMP_RD; both together -> load wins; Byte_count = 0 -> DONE directly, with no memory access and no stream transfer.
REQ-019 Starts outside IDLE are ignored.
REQ-020 LOAD_ACC: In_ready = 1; a word is captured on In_valid & In_ready; the next state is LOAD_WR.
REQ-021 LOAD_WR: one byte per cycle (Mem_we = 1); lane order per REQ-003; Mem_addr increments by 1 per byte.
REQ-022 After min(BYTES, remaining) bytes, LOAD_WR returns to LOAD_ACC, or goes to DONE when remaining = 0; unused lanes of the final partial word are discarded.
REQ-023 Load timing: In_ready = 0 throughout LOAD_WR, so one full word costs 1 + BYTES cycles minimum.
REQ-024 DUMP_RD: Mem_re = 1 for one byte per cycle; the returned byte goes into the lane given by REQ-003.
REQ-025 DUMP_RD leaves for DUMP_OUT after BYTES bytes or the final byte; unfilled lanes of a partial final word are 0.
REQ-026 DUMP_OUT: Out_valid = 1 and Out_data is held stable until Out_ready; on handshake the FSM goes to DUMP_RD, or to DONE if no bytes remain.
REQ-027 Address arithmetic is modulo 2^ADDR_W; on wrap from max to 0, Error is set and the operation continues.
REQ-028 Error clears only on reset or on the next accepted start.
REQ-029 DONE: Done = 1 for exactly one cycle, then IDLE.
REQ-030 Abort in any non-IDLE state -> IDLE on the next edge: no Done pulse, Mem_we/Mem_re deasserted that cycle, and any partial word is dropped.
REQ-031 Abort in IDLE has no effect; Abort together with a start in IDLE -> start ignored.
REQ-032 Mem_we and Mem_re are never asserted in the same cycle.

Reset
REQ-033 Reset_n low immediately forces IDLE and drives In_ready, Out_valid, Mem_we, Mem_re, Busy, Done and Error to 0, and Mem_addr, Mem_wdata and Out_data to 0.
REQ-034 A reset mid-operation discards all progress; bytes already written stay in memory.
REQ-035 After Reset_n rises, the first start is honoured on the first rising edge at which it is sampled high.

Verification
REQ-036 Default params, Base 0x010, Count 8, words 0x44332211, 0x88776655 -> writes 0x11..0x88 to 0x010..0x017 in order; Done pulses 1 cycle after the last write; Error = 0.
REQ-037 BIG_ENDIAN = 1, Base 0x000, Count 6, words 0xAABBCCDD, 0x11223344 -> memory 0x000..0x005 = AA BB CC DD 11 22; lanes 0x33 and 0x44 are never written.
REQ-038 Dump of Base 0x010, Count 8 after REQ-036 with Out_ready held low 5 cycles -> Out_data = 0x44332211 stable while stalled, then 0x88776655.
REQ-039 Load Base 0xFFE, Count 4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; Error = 1 from the wrap cycle onward; Done still pulses.
REQ-040 Start_load and Start_dump in the same cycle, Count 0 -> no Mem_we/Mem_re and no In_ready; Done 1 cycle later.
REQ-041 Abort during the 3rd byte of LOAD_WR -> IDLE next cycle, Busy = 0, no Done; a new load then runs correctly.

Source files
------------

// File: rtl/mem_image_loader.sv
// Moves a byte image between a word-wide valid/ready stream and a byte-wide memory port.
// Loads unpack stream words into byte writes; dumps pack byte reads back into stream words.
module mem_image_loader #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 12,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   byte_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int unsigned       BYTES     = DATA_W / 8;
    localparam int unsigned       LANE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   ONE_LEFT  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadAcc,
        StLoadWr,
        StDumpRd,
        StDumpOut,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [LANE_W-1:0] idx_q, idx_d;
    logic [LANE_W-1:0] rd_lane_q, rd_lane_d;
    logic              rd_pend_q, rd_pend_d;
    logic              error_q, error_d;
    logic [LANE_W-1:0] lane;

    // Byte index within the word, mapped onto the data lane it occupies.
    assign lane = BIG_ENDIAN ? (LAST_LANE - idx_q) : idx_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        word_d    = word_q;
        idx_d     = idx_q;
        rd_lane_d = rd_lane_q;
        rd_pend_d = 1'b0;
        error_d   = error_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        done      = 1'b0;

        // Read data returns one cycle after the strobe; drop it into the lane recorded then.
        if (rd_pend_q) begin
            word_d[rd_lane_q*8 +: 8] = mem_rdata;
        end

        unique case (state_q)
            StIdle: begin
                if (!abort && (start_load || start_dump)) begin
                    addr_d   = base_addr;
                    remain_d = byte_count;
                    idx_d    = '0;
                    word_d   = '0;
                    error_d  = 1'b0;
                    if (byte_count == '0) begin
                        state_d = StDone;
                    end else if (start_load) begin
                        state_d = StLoadAcc;
                    end else begin
                        state_d = StDumpRd;
                    end
                end
            end
            StLoadAcc: begin
                in_ready = !abort;
                if (in_valid && in_ready) begin
                    word_d  = in_data;
                    idx_d   = '0;
                    state_d = StLoadWr;
                end
            end
            StLoadWr: begin
                mem_we   = !abort;
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - ONE_LEFT;
                idx_d    = idx_q + LANE_W'(1);
                // Flag only a wrap that another byte will actually use.
                if (addr_q == '1 && remain_q != ONE_LEFT) begin
                    error_d = 1'b1;
                end
                if (remain_q == ONE_LEFT) begin
                    state_d = StDone;
                end else if (idx_q == LAST_LANE) begin
                    state_d = StLoadAcc;
                end
            end
            StDumpRd: begin
                mem_re    = !abort;
                rd_pend_d = !abort;
                rd_lane_d = lane;
                addr_d    = addr_q + ADDR_W'(1);
                remain_d  = remain_q - ONE_LEFT;
                idx_d     = idx_q + LANE_W'(1);
                if (addr_q == '1 && remain_q != ONE_LEFT) begin
                    error_d = 1'b1;
                end
                if (remain_q == ONE_LEFT || idx_q == LAST_LANE) begin
                    state_d = StDumpOut;
                end
            end
            StDumpOut: begin
                // Hold off until the last outstanding byte has landed in the word.
                out_valid = !rd_pend_q && !abort;
                if (out_valid && out_ready) begin
                    if (remain_q == '0) begin
                        state_d = StDone;
                    end else begin
                        word_d  = '0;
                        idx_d   = '0;
                        state_d = StDumpRd;
                    end
                end
            end
            StDone: begin
                done    = !abort;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            rd_pend_d = 1'b0;
            error_d   = error_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            remain_q  <= '0;
            word_q    <= '0;
            idx_q     <= '0;
            rd_lane_q <= '0;
            rd_pend_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            rd_lane_q <= rd_lane_d;
            rd_pend_q <= rd_pend_d;
            error_q   <= error_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = mem_we ? word_q[lane*8 +: 8] : 8'h00;
    assign out_data  = out_valid ? word_q : '0;
    assign busy      = (state_q != StIdle);
    assign error     = error_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// Runs a little-endian and a big-endian loader in lockstep on shared stimulus and checks both
// against a byte-level model of the image transfer.
module tb_mem_image_loader;
    localparam int NB     = 4;
    localparam int MEM_SZ = 4096;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  d_le;
        logic [7:0]  d_be;
        logic        err;
    } acc_t;

    typedef struct {
        logic [31:0] le;
        logic [31:0] be;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_clear;
    logic        start_load, start_dump, abort, in_valid, out_ready;
    logic [11:0] base_addr;
    logic [12:0] byte_count;
    logic [31:0] in_data;

    logic        in_ready_le, out_valid_le, mem_we_le, mem_re_le, busy_le, done_le, error_le;
    logic        in_ready_be, out_valid_be, mem_we_be, mem_re_be, busy_be, done_be, error_be;
    logic [31:0] out_data_le, out_data_be;
    logic [11:0] mem_addr_le, mem_addr_be;
    logic [7:0]  mem_wdata_le, mem_wdata_be, mem_rdata_le, mem_rdata_be;

    logic [7:0]  mem_le [MEM_SZ];
    logic [7:0]  mem_be [MEM_SZ];
    logic [7:0]  sh_le  [MEM_SZ];
    logic [7:0]  sh_be  [MEM_SZ];

    acc_t        wr_q[$];
    acc_t        rd_q[$];
    word_t       out_q[$];
    logic [31:0] feed_q[$];
    logic [31:0] got_le[$];
    logic [31:0] got_be[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_we_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_image_loader #(.DATA_W(32), .ADDR_W(12), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_dump(start_dump),
        .abort(abort), .base_addr(base_addr), .byte_count(byte_count),
        .in_valid(in_valid), .in_ready(in_ready_le), .in_data(in_data),
        .out_valid(out_valid_le), .out_ready(out_ready), .out_data(out_data_le),
        .mem_we(mem_we_le), .mem_re(mem_re_le), .mem_addr(mem_addr_le),
        .mem_wdata(mem_wdata_le), .mem_rdata(mem_rdata_le),
        .busy(busy_le), .done(done_le), .error(error_le)
    );

    mem_image_loader #(.DATA_W(32), .ADDR_W(12), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_dump(start_dump),
        .abort(abort), .base_addr(base_addr), .byte_count(byte_count),
        .in_valid(in_valid), .in_ready(in_ready_be), .in_data(in_data),
        .out_valid(out_valid_be), .out_ready(out_ready), .out_data(out_data_be),
        .mem_we(mem_we_be), .mem_re(mem_re_be), .mem_addr(mem_addr_be),
        .mem_wdata(mem_wdata_be), .mem_rdata(mem_rdata_be),
        .busy(busy_be), .done(done_be), .error(error_be)
    );

    // Byte memories with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_SZ; i++) begin
                mem_le[i] <= 8'h00;
                mem_be[i] <= 8'h00;
            end
        end
        if (mem_we_le) mem_le[mem_addr_le] <= mem_wdata_le;
        if (mem_we_be) mem_be[mem_addr_be] <= mem_wdata_be;
        if (mem_re_le) mem_rdata_le <= mem_le[mem_addr_le];
        if (mem_re_be) mem_rdata_be <= mem_be[mem_addr_be];
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: activity seen where the model expects none (cycle %0d)", name, cyc);
    endfunction

    always @(negedge clk) begin : compare
        acc_t e;
        if (rst_n) begin
            chk("le/be lockstep",
                32'({in_ready_le, out_valid_le, mem_we_le, mem_re_le, busy_le, done_le,
                     error_le, mem_addr_le}),
                32'({in_ready_be, out_valid_be, mem_we_be, mem_re_be, busy_be, done_be,
                     error_be, mem_addr_be}));
            chk("we/re exclusive", 32'(mem_we_le & mem_re_le), 32'd0);
            if (mem_we_le) begin
                if (wr_q.size() == 0) begin
                    unexpected("stray write");
                end else begin
                    e = wr_q.pop_front();
                    chk("write addr", 32'(mem_addr_le), 32'(e.addr));
                    chk("write data le", 32'(mem_wdata_le), 32'(e.d_le));
                    chk("write data be", 32'(mem_wdata_be), 32'(e.d_be));
                    chk("error at write", 32'(error_le), 32'(e.err));
                    last_we_cyc = cyc;
                end
            end
            if (mem_re_le) begin
                if (rd_q.size() == 0) begin
                    unexpected("stray read");
                end else begin
                    e = rd_q.pop_front();
                    chk("read addr", 32'(mem_addr_le), 32'(e.addr));
                    chk("error at read", 32'(error_le), 32'(e.err));
                end
            end
            if (out_valid_le) begin
                if (out_q.size() == 0) begin
                    unexpected("stray out_valid");
                end else begin
                    chk("out_data le", out_data_le, out_q[0].le);
                    chk("out_data be", out_data_be, out_q[0].be);
                    if (out_ready) void'(out_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte k of the image lives at base+k and comes from lane k%NB (LE) or NB-1-k%NB (BE).
    // With a continuously valid stream, byte k is written in cycle start+2+k+k/NB.
    task automatic plan_load(input logic [11:0] base, input int n, input int abort_cyc);
        for (int k = 0; k < n; k++) begin
            acc_t        e;
            logic [31:0] w;
            int          ln;
            if (abort_cyc > 0 && 2 + k + k / NB >= abort_cyc) break;
            w      = feed_q[k / NB];
            ln     = k % NB;
            e.addr = 12'((int'(base) + k) % MEM_SZ);
            e.d_le = w[8*ln +: 8];
            e.d_be = w[8*(NB-1-ln) +: 8];
            e.err  = (int'(base) + k) >= MEM_SZ;
            sh_le[e.addr] = e.d_le;
            sh_be[e.addr] = e.d_be;
            wr_q.push_back(e);
        end
    endtask

    task automatic plan_dump(input logic [11:0] base, input int n);
        word_t w;
        w.le = '0;
        w.be = '0;
        for (int k = 0; k < n; k++) begin
            acc_t e;
            int   ln;
            ln     = k % NB;
            e.addr = 12'((int'(base) + k) % MEM_SZ);
            e.d_le = '0;
            e.d_be = '0;
            e.err  = (int'(base) + k) >= MEM_SZ;
            rd_q.push_back(e);
            w.le[8*ln +: 8]        = sh_le[e.addr];
            w.be[8*(NB-1-ln) +: 8] = sh_be[e.addr];
            if (ln == NB - 1 || k == n - 1) begin
                out_q.push_back(w);
                w.le = '0;
                w.be = '0;
            end
        end
    endtask

    task automatic run_op(input bit ld, input bit dp, input logic [11:0] base, input int n,
                          input int stall, input int abort_cyc);
        int c0, done_cyc, seen_valid;
        bit hs_in, saw_ready;
        if (n > 0 && ld) plan_load(base, n, abort_cyc);
        else if (n > 0 && dp) plan_dump(base, n);
        start_load = ld;
        start_dump = dp;
        base_addr  = base;
        byte_count = 13'(n);
        in_valid   = 1'b0;
        out_ready  = (stall == 0);
        c0 = cyc;
        tick();
        start_load = 1'b0;
        start_dump = 1'b0;
        done_cyc   = -1;
        seen_valid = 0;
        saw_ready  = 1'b0;
        for (int i = 0; i < 200 && done_cyc < 0; i++) begin
            in_valid = ld && feed_q.size() > 0;
            in_data  = (feed_q.size() > 0) ? feed_q[0] : 32'h0;
            abort    = (abort_cyc > 0 && cyc == c0 + abort_cyc);
            @(negedge clk);
            if (in_ready_le) saw_ready = 1'b1;
            hs_in = in_valid && in_ready_le;
            if (out_valid_le) begin
                seen_valid++;
                if (out_ready) begin
                    got_le.push_back(out_data_le);
                    got_be.push_back(out_data_be);
                end
            end
            if (done_le) done_cyc = cyc;
            if (abort_cyc > 0 && cyc == c0 + abort_cyc + 1)
                chk("busy after abort", 32'(busy_le), 32'd0);
            tick();
            if (hs_in) void'(feed_q.pop_front());
            out_ready = (seen_valid >= stall);
            if (abort_cyc > 0 && cyc > c0 + abort_cyc + 4) break;
        end
        abort    = 1'b0;
        in_valid = 1'b0;
        if (abort_cyc > 0) begin
            chk("no done after abort", 32'(done_cyc >= 0), 32'd0);
            feed_q.delete();
        end else if (done_cyc < 0) begin
            unexpected("done timeout");
        end else begin
            if (ld && n > 0) begin
                chk("done one cycle after last write", 32'(done_cyc - last_we_cyc), 32'd1);
                chk("load cycle count", 32'(done_cyc - c0), 32'(1 + (n + NB - 1) / NB + n));
            end
            if (n == 0) begin
                chk("count0 done latency", 32'(done_cyc - c0), 32'd1);
                chk("count0 in_ready never", 32'(saw_ready), 32'd0);
            end
            @(negedge clk);
            chk("done single pulse", 32'(done_le), 32'd0);
            chk("idle after done", 32'(busy_le), 32'd0);
            tick();
        end
        chk("writes drained", 32'(wr_q.size()), 32'd0);
        chk("reads drained", 32'(rd_q.size()), 32'd0);
        chk("words drained", 32'(out_q.size() + feed_q.size()), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_clear  = 1'b1;
        start_load = 1'b0;
        start_dump = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_data    = '0;
        base_addr  = '0;
        byte_count = '0;
        for (int i = 0; i < MEM_SZ; i++) begin
            sh_le[i] = 8'h00;
            sh_be[i] = 8'h00;
        end
        #12;
        chk("reset strobes", 32'({in_ready_le, out_valid_le, mem_we_le, mem_re_le}), 32'd0);
        chk("reset busy", 32'(busy_le), 32'd0);
        chk("reset done", 32'(done_le), 32'd0);
        chk("reset error", 32'(error_le | error_be), 32'd0);
        chk("reset mem_addr", 32'(mem_addr_le), 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata_le), 32'd0);
        chk("reset out_data", out_data_le | out_data_be, 32'd0);
        tick();
        rst_n     = 1'b1;
        mem_clear = 1'b0;

        // Little-endian image load, then dump with a 5-cycle stall.
        feed_q = '{32'h44332211, 32'h88776655};
        run_op(1'b1, 1'b0, 12'h010, 8, 0, 0);
        for (int i = 0; i < 8; i++) chk("load image le", 32'(mem_le[12'h010 + i]), 32'(8'h11 * (i + 1)));
        chk("load error", 32'(error_le), 32'd0);
        run_op(1'b0, 1'b1, 12'h010, 8, 5, 0);
        chk("dump word0 le", got_le[0], 32'h44332211);
        chk("dump word1 le", got_le[1], 32'h88776655);
        chk("dump word0 be", got_be[0], 32'h44332211);
        got_le.delete();
        got_be.delete();

        // Partial final word: trailing lanes never written.
        feed_q = '{32'hAABBCCDD, 32'h11223344};
        run_op(1'b1, 1'b0, 12'h000, 6, 0, 0);
        chk("be image 0-3", {mem_be[0], mem_be[1], mem_be[2], mem_be[3]}, 32'hAABBCCDD);
        chk("be image 4-7", {mem_be[4], mem_be[5], mem_be[6], mem_be[7]}, 32'h11220000);
        chk("le image 4-7", {mem_le[4], mem_le[5], mem_le[6], mem_le[7]}, 32'h44330000);

        // Address wrap sets the sticky error but the operation completes.
        feed_q = '{32'h04030201};
        run_op(1'b1, 1'b0, 12'hFFE, 4, 0, 0);
        chk("wrap image", {mem_le[12'hFFE], mem_le[12'hFFF], mem_le[0], mem_le[1]}, 32'h01020304);
        chk("wrap error sticky", 32'(error_le), 32'd1);
        run_op(1'b0, 1'b1, 12'hFFE, 4, 0, 0);
        chk("wrap dump le", got_le[0], 32'h04030201);
        got_le.delete();
        got_be.delete();

        // Both starts with a zero count: straight to Done, error cleared by the start.
        run_op(1'b1, 1'b1, 12'h020, 0, 0, 0);
        chk("error cleared by start", 32'(error_le), 32'd0);

        // Abort alongside a start in idle: nothing happens.
        abort      = 1'b1;
        start_load = 1'b1;
        base_addr  = 12'h200;
        byte_count = 13'd4;
        tick();
        abort      = 1'b0;
        start_load = 1'b0;
        @(negedge clk);
        chk("abort+start ignored", 32'({busy_le, in_ready_le}), 32'd0);
        tick();

        // Abort on the third written byte, then a clean reload and dump of a partial image.
        feed_q = '{32'h55555555, 32'h66666666};
        run_op(1'b1, 1'b0, 12'h100, 8, 0, 4);
        feed_q = '{32'hDEADBEEF, 32'h000000A5};
        run_op(1'b1, 1'b0, 12'h100, 5, 0, 0);
        chk("reload image", {mem_le[12'h100], mem_le[12'h101], mem_le[12'h102], mem_le[12'h103]},
            32'hEFBEADDE);
        chk("reload tail", 32'(mem_le[12'h104]), 32'hA5);
        run_op(1'b0, 1'b1, 12'h100, 5, 0, 0);
        chk("partial dump word0 le", got_le[0], 32'hDEADBEEF);
        chk("partial dump word1 le", got_le[1], 32'h000000A5);
        chk("partial dump word1 be", got_be[1], 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
